// File: rtl/tile_spawner_pkg.sv
// tile_spawner_pkg: shared state type, constants and LFSR step for the tile spawner.
package tile_spawner_pkg;
   typedef enum logic [1:0] {IDLE, SPAWN, ACTIVE, WAIT} state_t;
   localparam int FIXED_POINT_MULTIPLIER = 64;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int Y_FRAME_LIMIT = 479;
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction
endpackage

// File: rtl/tile_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, reloaded with seed on reset.
module lfsr16
   import tile_spawner_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] value
);
   logic [15:0] r_value;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_value <= seed;
      else       r_value <= lfsr_step(r_value);
   assign value = r_value;
endmodule

// File: rtl/tile_spawner.sv
// tile_spawner: spawns one falling tile at a random lane with level-scaled speed,
// respawns after a random frame gap and counts tiles that passed untouched.
module tile_spawner
   import tile_spawner_pkg::*;
#(
   parameter int          NUM_LANES  = 5,
   parameter int          LANE_X0    = 32,
   parameter int          LANE_WIDTH = 96,
   parameter int          SPAWN_Y    = -32,
   parameter int          BASE_SPEED = 64,
   parameter int          SPEED_STEP = 16,
   parameter int          MAX_SPEED  = 160,
   parameter int          MIN_GAP    = 2,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic [2:0]         level,
   input  logic               exceed,
   input  logic               collision,
   output logic signed [10:0] initialX,
   output logic signed [10:0] initialY,
   output logic               load,
   output logic               visible,
   output logic signed [31:0] speed,
   output logic [7:0]         tilesPassed
);
   state_t             r_state, w_next;
   logic [15:0]        w_lfsr;
   logic               w_unused_lfsr_hi;
   logic [2:0]         w_r, w_lane;
   logic signed [10:0] w_x;
   logic [7:0]         w_gap;
   int                 w_speed_raw;
   logic signed [31:0] w_speed;
   logic signed [10:0] r_x, r_y;
   logic signed [31:0] r_speed;
   logic [7:0]         r_passed, r_gap_cnt;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .value (w_lfsr)
   );

   assign w_unused_lfsr_hi = ^w_lfsr[15:6];
   assign w_r         = w_lfsr[2:0];
   assign w_lane      = (int'(w_r) < NUM_LANES) ? w_r : w_r - 3'(NUM_LANES);
   assign w_x         = 11'(LANE_X0 + int'(w_lane) * LANE_WIDTH);
   assign w_gap       = 8'(MIN_GAP) + {5'd0, w_lfsr[5:3]};
   assign w_speed_raw = BASE_SPEED + int'(level) * SPEED_STEP;
   assign w_speed     = (w_speed_raw > MAX_SPEED) ? MAX_SPEED : w_speed_raw;

   // Dropping enable overrides every other transition.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = enable ? SPAWN : IDLE;
         SPAWN:   w_next = ACTIVE;
         ACTIVE:  w_next = (collision || exceed) ? WAIT : ACTIVE;
         WAIT:    w_next = (startOfFrame && r_gap_cnt <= 8'd1) ? SPAWN : WAIT;
         default: w_next = IDLE;
      endcase
      if (!enable) w_next = IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state   <= IDLE;
         r_x       <= 11'(LANE_X0);
         r_y       <= 11'(SPAWN_Y);
         r_speed   <= BASE_SPEED;
         r_passed  <= 8'd0;
         r_gap_cnt <= 8'd0;
      end else begin
         r_state <= w_next;
         if (w_next == SPAWN) begin
            r_x     <= w_x;
            r_y     <= 11'(SPAWN_Y);
            r_speed <= w_speed;
         end
         if (w_next == WAIT && r_state != WAIT) r_gap_cnt <= w_gap;
         else if (r_state == WAIT && startOfFrame) r_gap_cnt <= r_gap_cnt - 8'd1;
         // Collision wins over exceed, so only an uncontested exceed counts.
         if (r_state == ACTIVE && w_next == WAIT && !collision && r_passed != 8'hFF)
            r_passed <= r_passed + 8'd1;
      end

   assign initialX    = r_x;
   assign initialY    = r_y;
   assign speed       = r_speed;
   assign tilesPassed = r_passed;
   assign load        = (r_state == SPAWN);
   assign visible     = (r_state == ACTIVE);
endmodule
